// File: rtl/lifo_fifo_pkg.sv
// Shared types and default sizing for the dual-mode LIFO/FIFO buffer.
package lifo_fifo_pkg;

  typedef enum logic {
    MODE_LIFO = 1'b0,
    MODE_FIFO = 1'b1
  } mode_e;

  localparam int DEF_DWIDTH   = 8;
  localparam int DEF_AWIDTH   = 3;
  localparam int DEF_AE_LEVEL = 1;

endpackage

// File: rtl/buf_mem.sv
// Simple dual-port RAM: synchronous write, registered read (read-first on same address).
module buf_mem #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 3
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AWIDTH-1:0] i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2**AWIDTH;

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Output register holds between reads; only it is reset, never the array.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)  r_rdata <= '0;
    else if (i_re)  r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lifo_fifo_buf.sv
// Buffer selectable between LIFO (stack) and FIFO order; mode switches only when idle and empty.
module lifo_fifo_buf
  import lifo_fifo_pkg::*;
#(
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int AF_LEVEL = (2**AWIDTH) - 2,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              mode_i,
  input  logic              flush_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              mode_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] C_FULL = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] C_AF   = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0] C_AE   = (AWIDTH+1)'(AE_LEVEL);

  mode_e             r_mode;
  logic [AWIDTH:0]   r_usedw;
  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic              r_ovf;
  logic              r_udf;

  logic              w_empty;
  logic              w_full;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [AWIDTH-1:0] w_sp_top;
  logic [AWIDTH-1:0] w_waddr;
  logic [AWIDTH-1:0] w_raddr;

  assign w_empty = (r_usedw == '0);
  assign w_full  = (r_usedw == C_FULL);

  // A write while full is still accepted when paired with a read (full implies not empty).
  assign w_rd_ok  = rdreq_i & ~w_empty;
  assign w_wr_ok  = wrreq_i & (~w_full | rdreq_i);
  assign w_mem_we = w_wr_ok & ~flush_i;
  assign w_mem_re = w_rd_ok & ~flush_i;

  // Stack top is usedw-1; at usedw==DEPTH the low bits are 0, so the wrap yields DEPTH-1.
  assign w_sp_top = r_usedw[AWIDTH-1:0] - AWIDTH'(1);

  always_comb begin
    w_waddr = r_wr_ptr;
    w_raddr = r_rd_ptr;
    if (r_mode == MODE_LIFO) begin
      w_raddr = w_sp_top;
      w_waddr = w_rd_ok ? w_sp_top : r_usedw[AWIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_mode   <= MODE_LIFO;
      r_usedw  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_empty && !wrreq_i && !rdreq_i) r_mode <= mode_e'(mode_i);
      if (flush_i) begin
        r_usedw  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_ovf    <= 1'b0;
        r_udf    <= 1'b0;
      end else begin
        if (w_wr_ok && !w_rd_ok)      r_usedw <= r_usedw + (AWIDTH+1)'(1);
        else if (w_rd_ok && !w_wr_ok) r_usedw <= r_usedw - (AWIDTH+1)'(1);
        if (r_mode == MODE_FIFO) begin
          if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
          if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
        end
        if (wrreq_i && !rdreq_i && w_full) r_ovf <= 1'b1;
        if (rdreq_i && w_empty)            r_udf <= 1'b1;
      end
    end
  end

  buf_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .i_clk    (clk_i),
    .i_arst_n (arst_n_i),
    .i_we     (w_mem_we),
    .i_waddr  (w_waddr),
    .i_wdata  (data_i),
    .i_re     (w_mem_re),
    .i_raddr  (w_raddr),
    .o_rdata  (q_o)
  );

  assign empty_o        = w_empty;
  assign full_o         = w_full;
  assign almost_empty_o = (r_usedw <= C_AE);
  assign almost_full_o  = (r_usedw >= C_AF);
  assign usedw_o        = r_usedw;
  assign mode_o         = r_mode;
  assign ovf_o          = r_ovf;
  assign udf_o          = r_udf;

endmodule

// File: tb/tb_lifo_fifo_buf.sv
// Directed bench for lifo_fifo_buf: vector table for bulk LIFO/FIFO traffic, hand sequences for corners.
module tb_lifo_fifo_buf;

  logic       clk;
  logic       arst_n;
  logic       mode_in;
  logic       flush;
  logic       wrreq;
  logic       rdreq;
  logic [7:0] data;
  logic [7:0] q;
  logic       empty, full, aempty, afull;
  logic [3:0] usedw;
  logic       mode_out;
  logic       ovf, udf;

  int n_pass  = 0;
  int n_total = 0;

  lifo_fifo_buf #(
    .DWIDTH   (8),
    .AWIDTH   (3),
    .AF_LEVEL (6),
    .AE_LEVEL (1)
  ) dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n),
    .mode_i         (mode_in),
    .flush_i        (flush),
    .wrreq_i        (wrreq),
    .rdreq_i        (rdreq),
    .data_i         (data),
    .q_o            (q),
    .empty_o        (empty),
    .full_o         (full),
    .almost_empty_o (aempty),
    .almost_full_o  (afull),
    .usedw_o        (usedw),
    .mode_o         (mode_out),
    .ovf_o          (ovf),
    .udf_o          (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       md;
    logic [7:0] d;
    logic [7:0] q;
    logic [3:0] uw;
    logic       mo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_v(logic wr, logic rd, logic md, logic [7:0] d,
                                logic [7:0] eq, logic [3:0] uw, logic mo);
    vec_t v;
    v.wr = wr; v.rd = rd; v.md = md; v.d = d; v.q = eq; v.uw = uw; v.mo = mo;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(logic wr, logic rd, logic md, logic fl, logic [7:0] d);
    wrreq = wr; rdreq = rd; mode_in = md; flush = fl; data = d;
    @(posedge clk);
    #1;
    wrreq = 1'b0; rdreq = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_state(string nm, logic [7:0] eq, logic [3:0] uw);
    chk({nm, ".q"},     32'(q),     32'(eq));
    chk({nm, ".usedw"}, 32'(usedw), 32'(uw));
    chk({nm, ".empty"}, 32'(empty), 32'(uw == 4'd0));
    chk({nm, ".full"},  32'(full),  32'(uw == 4'd8));
    chk({nm, ".ae"},    32'(aempty), 32'(uw <= 4'd1));
    chk({nm, ".af"},    32'(afull),  32'(uw >= 4'd6));
  endtask

  initial begin
    arst_n = 1'b0; mode_in = 1'b0; flush = 1'b0; wrreq = 1'b0; rdreq = 1'b0; data = '0;

    // LIFO fill/drain, switch to FIFO, FIFO fill/drain, then mixed traffic across the pointer wrap
    for (int i = 0; i < 8; i++) add_v(1, 0, 0, 8'(8'h10 + i), 8'h00, 4'(i + 1), 0);
    for (int i = 0; i < 8; i++) add_v(0, 1, 0, 8'h00, 8'(8'h17 - i), 4'(7 - i), 0);
    add_v(0, 0, 1, 8'h00, 8'h10, 4'd0, 1);
    for (int i = 0; i < 8; i++) add_v(1, 0, 1, 8'(8'h20 + i), 8'h10, 4'(i + 1), 1);
    for (int i = 0; i < 8; i++) add_v(0, 1, 1, 8'h00, 8'(8'h20 + i), 4'(7 - i), 1);
    for (int i = 0; i < 6; i++) add_v(1, 0, 1, 8'(8'h30 + i), 8'h27, 4'(i + 1), 1);
    for (int i = 0; i < 3; i++) add_v(1, 1, 1, 8'(8'h36 + i), 8'(8'h30 + i), 4'd6, 1);
    for (int i = 0; i < 6; i++) add_v(0, 1, 1, 8'h00, 8'(8'h33 + i), 4'(5 - i), 1);

    #1;
    chk_state("reset", 8'h00, 4'd0);
    chk("reset.mode", 32'(mode_out), 32'd0);
    chk("reset.ovf",  32'(ovf), 32'd0);
    chk("reset.udf",  32'(udf), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    foreach (tbl[k]) begin
      cyc(tbl[k].wr, tbl[k].rd, tbl[k].md, 1'b0, tbl[k].d);
      chk_state($sformatf("vec%0d", k), tbl[k].q, tbl[k].uw);
      chk($sformatf("vec%0d.mode", k), 32'(mode_out), 32'(tbl[k].mo));
    end

    // Overflow on full LIFO, then underflow on empty
    cyc(0, 0, 0, 0, 8'h00);
    chk("ovf.mode", 32'(mode_out), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 8'hEE);
    chk_state("ovf", 8'h38, 4'd8);
    chk("ovf.flag", 32'(ovf), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 8'h00);
      chk($sformatf("ovf.pop%0d", i), 32'(q), 32'(8'h47 - i));
    end
    cyc(0, 1, 0, 0, 8'h00);
    chk_state("udf", 8'h40, 4'd0);
    chk("udf.flag", 32'(udf), 32'd1);
    chk("udf.ovf_sticky", 32'(ovf), 32'd1);

    // Flush with 4 words overrides a same-cycle write
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 8'(8'h50 + i));
    chk("flush.pre", 32'(usedw), 32'd4);
    cyc(1, 0, 0, 1, 8'hAA);
    chk_state("flush", 8'h40, 4'd0);
    chk("flush.ovf", 32'(ovf), 32'd0);
    chk("flush.udf", 32'(udf), 32'd0);
    cyc(1, 0, 0, 0, 8'h60);
    cyc(0, 1, 0, 0, 8'h00);
    chk_state("flush.sp0", 8'h60, 4'd0);

    // LIFO simultaneous read+write replaces top
    cyc(1, 0, 0, 0, 8'h01);
    cyc(1, 0, 0, 0, 8'h02);
    cyc(1, 1, 0, 0, 8'h03);
    chk_state("lrw", 8'h02, 4'd2);
    cyc(0, 1, 0, 0, 8'h00);
    chk_state("lrw.pop1", 8'h03, 4'd1);
    cyc(0, 1, 0, 0, 8'h00);
    chk_state("lrw.pop2", 8'h01, 4'd0);

    // Read+write while empty: write taken, read dropped
    cyc(1, 1, 0, 0, 8'h09);
    chk_state("erw", 8'h01, 4'd1);
    chk("erw.udf", 32'(udf), 32'd1);
    cyc(0, 1, 0, 0, 8'h00);
    chk_state("erw.pop", 8'h09, 4'd0);
    cyc(0, 0, 0, 1, 8'h00);
    chk("erw.flush_udf", 32'(udf), 32'd0);

    // Mode request ignored while not empty or not idle
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 8'(8'h71 + i));
    cyc(0, 0, 1, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    chk("mode.hold3", 32'(mode_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 8'h00);
      chk($sformatf("mode.pop%0d", i), 32'(q), 32'(8'h73 - i));
      chk($sformatf("mode.held%0d", i), 32'(mode_out), 32'd0);
    end
    cyc(0, 0, 1, 0, 8'h00);
    chk("mode.follow", 32'(mode_out), 32'd1);

    // FIFO full with simultaneous read+write
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, 8'(8'h80 + i));
    cyc(1, 1, 1, 0, 8'h88);
    chk_state("ffrw", 8'h80, 4'd8);
    chk("ffrw.ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, 0, 8'h00);
      chk($sformatf("ffrw.pop%0d", i), 32'(q), 32'(8'h81 + i));
    end
    chk("ffrw.empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-cycle with 5 stored words
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 8'(8'h90 + i));
    cyc(0, 1, 1, 0, 8'h00);
    cyc(1, 0, 1, 0, 8'h95);
    cyc(0, 0, 0, 0, 8'h00);
    chk("arst.pre", 32'(usedw), 32'd5);
    cyc(1, 1, 0, 0, 8'h00);
    chk("arst.pre_q", 32'(q), 32'h91);
    #2;
    arst_n = 1'b0;
    #1;
    chk_state("arst", 8'h00, 4'd0);
    chk("arst.mode", 32'(mode_out), 32'd0);
    chk("arst.ovf",  32'(ovf), 32'd0);
    chk("arst.udf",  32'(udf), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    cyc(0, 1, 0, 0, 8'h00);
    chk_state("arst.discard", 8'h00, 4'd0);
    chk("arst.udf_after", 32'(udf), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
